// File: rtl/cbd_sampler.sv
// Centred-binomial sampler for the Kyber noise path.
// Consumes a PRF byte stream over a ready/valid input bus and emits one
// 256-coefficient polynomial, LANES coefficients per output beat, with
// eta selectable per polynomial (2 or 3). Output coefficients are either
// signed 3-bit values (MODQ=0) or reduced into [0, 3329) (MODQ=1).
module cbd_sampler #(
    parameter int IW    = 64,
    parameter int LANES = 8,
    parameter int MODQ  = 0,
    localparam int CW   = (MODQ != 0) ? 12 : 3
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [1:0]            i_eta,
    input  logic [IW-1:0]         i_ibytes,
    input  logic                  i_ibytes_valid,
    output logic                  o_ibytes_ready,
    output logic [LANES*CW-1:0]   o_coeffs,
    output logic                  o_coeffs_valid,
    input  logic                  i_coeffs_ready,
    output logic                  o_done,
    output logic                  o_err
);

    // Bit buffer holds one input word plus the largest beat's worth of
    // leftover bits, so an append is always possible once a beat drains.
    localparam int BW     = IW + 6 * LANES;
    localparam int FW     = $clog2(BW + 1);
    localparam int NBEATS = 256 / LANES;
    localparam int BCW    = $clog2(NBEATS + 1);
    localparam int BUDW   = 11;                 // holds up to 3*512 bits
    localparam logic [11:0] Q = 12'd3329;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [BW-1:0]         bits;                // bit 0 is the oldest stream bit
    logic [FW-1:0]         fill;
    logic [BUDW-1:0]       budget;              // input bits still to accept
    logic [BCW-1:0]        beats_left;          // beats still to form
    logic                  eta_is3;             // latched eta: 0 -> 2, 1 -> 3
    logic [LANES*CW-1:0]   coeffs;
    logic                  coeffs_valid;
    logic                  err;

    logic                  start_ok;
    logic                  start_bad;
    logic                  ibytes_ready;
    logic                  in_take;
    logic                  out_take;
    logic                  beat_fire;
    logic [FW-1:0]         need;
    logic [IW-1:0]         word_lsb;
    logic [BW-1:0]         kept;
    logic [FW-1:0]         kept_fill;
    logic [BW-1:0]         bits_next;
    logic [FW-1:0]         fill_next;
    logic [LANES*CW-1:0]   beat_next;

    // One coefficient from a group of 2*eta stream bits (grp[0] is first).
    function automatic logic [CW-1:0] lane_value(input logic [5:0] grp,
                                                 input logic       is3);
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] c;
        if (is3) begin
            a = {1'b0, grp[0]} + {1'b0, grp[1]} + {1'b0, grp[2]};
            b = {1'b0, grp[3]} + {1'b0, grp[4]} + {1'b0, grp[5]};
        end else begin
            a = {1'b0, grp[0]} + {1'b0, grp[1]};
            b = {1'b0, grp[2]} + {1'b0, grp[3]};
        end
        c = {1'b0, a} - {1'b0, b};
        if (MODQ != 0) begin
            // Adding the sign-extended negative value to q wraps into 3326..3328.
            return CW'(c[2] ? (Q + {{9{1'b1}}, c}) : {9'b0, c});
        end else begin
            return CW'(c);
        end
    endfunction

    // Handshake and control decode from registered state.
    assign start_ok     = (state == S_IDLE) && i_start &&  i_eta[1];
    assign start_bad    = (state == S_IDLE) && i_start && !i_eta[1];
    assign ibytes_ready = (state == S_RUN) && (budget != '0) &&
                          (int'(fill) + IW <= BW);
    assign in_take      = i_ibytes_valid && ibytes_ready;
    assign out_take     = coeffs_valid && i_coeffs_ready;
    assign need         = eta_is3 ? FW'(6 * LANES) : FW'(4 * LANES);
    assign beat_fire    = (state == S_RUN) && (beats_left != '0) &&
                          (fill >= need) && (!coeffs_valid || i_coeffs_ready);

    // Reorder the input word so stream bit n sits at word_lsb[n]:
    // first byte at the top of the bus, LSB first within each byte.
    always_comb begin
        word_lsb = '0;
        for (int i = 0; i < IW / 8; i++) begin
            word_lsb[8*i +: 8] = i_ibytes[IW-1-8*i -: 8];
        end
    end

    // Next buffer contents: drop the bits of a forming beat, then append
    // the accepted word right above whatever remains.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        kept      = beat_fire ? (bits >> need) : bits;
        kept_fill = beat_fire ? (fill - need) : fill;
        bits_next = kept;
        fill_next = kept_fill;
        if (in_take) begin
            bits_next = kept | ({{(BW-IW){1'b0}}, word_lsb} << kept_fill);
            fill_next = kept_fill + FW'(IW);
        end
    end

    // Coefficient extraction for the beat at the head of the buffer.
    always_comb begin
        beat_next = '0;
        for (int j = 0; j < LANES; j++) begin
            beat_next[CW*j +: CW] = lane_value(
                eta_is3 ? bits[6*j +: 6] : {2'b00, bits[4*j +: 4]}, eta_is3);
        end
    end

    // Next-state logic: IDLE -> RUN on a legal start, RUN -> DONE once the
    // final beat is accepted, DONE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_RUN;
            S_RUN:   if (out_take && (beats_left == '0)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: bit buffer, budget, beat counter, output beat, error pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            // NOTE: the bit buffer is reset along with its fill count so a mid-run reset discards stale stream bits.
            bits         <= '0;
            fill         <= '0;
            budget       <= '0;
            beats_left   <= '0;
            eta_is3      <= 1'b0;
            coeffs       <= '0;
            coeffs_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            err <= start_bad;
            if (start_ok) begin
                eta_is3    <= i_eta[0];
                budget     <= i_eta[0] ? BUDW'(1536) : BUDW'(1024);
                beats_left <= BCW'(NBEATS);
                bits       <= '0;
                fill       <= '0;
            end else begin
                bits <= bits_next;
                fill <= fill_next;
                if (in_take) begin
                    budget <= budget - BUDW'(IW);
                end
                if (beat_fire) begin
                    beats_left <= beats_left - BCW'(1);
                end
            end
            if (beat_fire) begin
                coeffs       <= beat_next;
                coeffs_valid <= 1'b1;
            end else if (out_take) begin
                coeffs_valid <= 1'b0;
            end
        end
    end

    assign o_ibytes_ready = ibytes_ready;
    assign o_coeffs       = coeffs;
    assign o_coeffs_valid = coeffs_valid;
    assign o_done         = (state == S_DONE);
    assign o_err          = err;

endmodule
